// File: rtl/mmm_result_buf_if.sv
// Stream and control bundle between the MMM datapath/exponentiation controller
// and the multi-word result buffer.
interface mmm_result_buf_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             clr;
  logic             en;
  logic             ld_r;
  logic             lock;
  logic [WIDTH-1:0] reg_rji;
  logic [WIDTH-1:0] A;
  logic             start_rd;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] R_i;
  logic             full;
  logic [PTR_W:0]   wr_cnt;
  logic             ovf;

  // The controller side drives loads, drain requests and sink readiness.
  modport master (
    output clr, en, ld_r, lock, reg_rji, A, start_rd, out_ready,
    input  out_valid, out_data, R_i, full, wr_cnt, ovf
  );

  modport slave (
    input  clr, en, ld_r, lock, reg_rji, A, start_rd, out_ready,
    output out_valid, out_data, R_i, full, wr_cnt, ovf
  );
endinterface

// File: rtl/mmm_result_buf.sv
// Multi-word MMM result store: fills DEPTH words from reg_rji/A, then drains them
// in write order over a valid/ready stream. Loads outside LOAD raise a sticky ovf.
module mmm_result_buf #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  mmm_result_buf_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   r_i;
  logic [CNT_W-1:0]   wr_cnt;
  logic [PTR_W-1:0]   rd_ptr;
  logic               ovf;

  logic               wr_req;
  logic               wr_fire;
  logic               ovf_set;
  logic               start_fire;
  logic               hs;
  logic               last_hs;
  logic [WIDTH-1:0]   wr_word;
  logic [PTR_W-1:0]   wr_idx;

  assign wr_req  = bus.en & bus.ld_r;
  assign wr_word = bus.lock ? bus.reg_rji : bus.A;
  assign wr_idx  = wr_cnt[PTR_W-1:0];

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    wr_fire    = 1'b0;
    ovf_set    = 1'b0;
    start_fire = 1'b0;
    hs         = 1'b0;
    last_hs    = 1'b0;
    case (state)
      ST_LOAD: begin
        if (wr_req) begin
          wr_fire = 1'b1;
          if (wr_cnt == CNT_W'(DEPTH - 1)) state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        ovf_set = wr_req;
        if (bus.start_rd) begin
          start_fire = 1'b1;
          state_nxt  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // out_valid is asserted for the whole of DRAIN, so readiness alone is a handshake.
        ovf_set = wr_req;
        if (bus.out_ready) begin
          hs = 1'b1;
          if (rd_ptr == PTR_W'(DEPTH - 1)) begin
            last_hs   = 1'b1;
            state_nxt = ST_LOAD;
          end
        end
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) state <= ST_LOAD;
    else                state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      // NOTE: the word store is cleared on reset/clear on purpose: an MMM restart
      // must not expose the previous operand's words on out_data or R_i.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      r_i    <= '0;
      wr_cnt <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_fire) begin
        mem[wr_idx] <= wr_word;
        r_i         <= wr_word;
        wr_cnt      <= wr_cnt + 1'b1;
      end
      if (ovf_set)    ovf    <= 1'b1;
      if (start_fire) rd_ptr <= '0;
      if (hs) begin
        if (last_hs) begin
          rd_ptr <= '0;
          wr_cnt <= '0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = (state == ST_DRAIN);
  assign bus.full      = (state != ST_LOAD);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.R_i       = r_i;
  assign bus.wr_cnt    = wr_cnt;
  assign bus.ovf       = ovf;
endmodule
